// File: rtl/pol2rec_pkg.sv
// Shared constants for the polar-to-rectangular CORDIC: arctangent table in
// degrees x1024, CORDIC gain compensation, angle landmarks and FSM states.
package pol2rec_pkg;

  localparam int ATAN_N = 16;
  localparam int ATAN_TABLE [ATAN_N] = '{
    46080, 27203, 14373, 7296, 3662, 1833, 917, 458,
    229, 115, 57, 29, 14, 7, 4, 2
  };

  // 1/K = 0.6072529 in Q16
  localparam int INV_K  = 39797;
  localparam int DEG90  = 92160;
  localparam int DEG180 = 184320;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    SCALE,
    OUT
  } state_t;

endpackage

// File: rtl/pol2rec_atan_rom.sv
// Combinational arctangent lookup: micro-rotation index -> atan(2^-i) in
// degrees x1024, AW bits wide.
module pol2rec_atan_rom
  import pol2rec_pkg::*;
#(
  parameter int AW = 19
) (
  input  logic [3:0]           idx,
  output logic signed [AW-1:0] atan
);

  logic signed [AW-1:0] atan_tbl [ATAN_N];

  for (genvar gi = 0; gi < ATAN_N; gi++) begin : g_tbl
    assign atan_tbl[gi] = AW'(ATAN_TABLE[gi]);
  end

  assign atan = atan_tbl[idx];

endmodule

// File: rtl/pol2rec.sv
// Iterative rotation-mode CORDIC: (modulus, angle in deg x1024) -> (x, y).
// Build option: define POL2REC_ROUND_EN to round the gain-compensated result.
module pol2rec
  import pol2rec_pkg::*;
#(
  parameter int ITER = 16,
  parameter int MW   = 13,
  parameter int AW   = 19,
  parameter int OW   = 14,
  parameter int GW   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [MW-1:0]        mod,
  input  logic signed [AW-1:0] angle,
  output logic signed [OW-1:0] x,
  output logic signed [OW-1:0] y,
  output logic                 busy,
  output logic                 done
);

  // One bit above MW+GW+1 absorbs the ~1.65 CORDIC gain before compensation.
  localparam int XW = MW + GW + 2;
  localparam int PW = XW + 17;
  localparam int CW = 4;
  localparam int SH = 16 + GW;

  localparam logic signed [AW-1:0] Z90  = AW'(DEG90);
  localparam logic signed [XW-1:0] XMAX = XW'((1 << (OW - 1)) - 1);
  localparam logic signed [XW-1:0] XMIN = -XMAX;
  localparam logic signed [PW-1:0] KINV = PW'(INV_K);

  state_t               state_reg, state_next;
  logic [CW-1:0]        iter_reg;
  logic signed [XW-1:0] x_reg, y_reg;
  logic signed [AW-1:0] z_reg;
  logic signed [OW-1:0] x_out_reg, y_out_reg;
  logic                 busy_reg, done_reg;

  logic signed [AW-1:0] atan_val;
  logic signed [XW-1:0] mod_s, xi, yi, xsh, ysh, x_rot, y_rot;
  logic signed [AW-1:0] zi, z_rot;
  logic signed [PW-1:0] x_prod, y_prod, x_pre, y_pre;

  pol2rec_atan_rom #(.AW(AW)) u_atan_rom (
    .idx  (iter_reg),
    .atan (atan_val)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else if (enable) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ROT;
      ROT:     if (iter_reg == CW'(ITER - 1)) state_next = SCALE;
      SCALE:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Quadrant pre-rotation keeps the residual angle inside CORDIC convergence.
  assign mod_s = $signed({2'b00, mod, {GW{1'b0}}});

  always_comb begin
    xi = mod_s;
    yi = '0;
    zi = angle;
    if (angle > Z90) begin
      xi = '0;
      yi = mod_s;
      zi = angle - Z90;
    end else if (angle < -Z90) begin
      xi = '0;
      yi = -mod_s;
      zi = angle + Z90;
    end
  end

  always_comb begin
    xsh = x_reg >>> iter_reg;
    ysh = y_reg >>> iter_reg;
    if (!z_reg[AW-1]) begin
      x_rot = x_reg - ysh;
      y_rot = y_reg + xsh;
      z_rot = z_reg - atan_val;
    end else begin
      x_rot = x_reg + ysh;
      y_rot = y_reg - xsh;
      z_rot = z_reg + atan_val;
    end
  end

  assign x_prod = PW'(x_reg) * KINV;
  assign y_prod = PW'(y_reg) * KINV;

`ifdef POL2REC_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (SH - 1);
  assign x_pre = x_prod + RND;
  assign y_pre = y_prod + RND;
`else
  assign x_pre = x_prod;
  assign y_pre = y_prod;
`endif

  function automatic logic signed [OW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > XMAX)      return OW'(XMAX);
    else if (v < XMIN) return OW'(XMIN);
    else               return OW'(v);
  endfunction

  // done is a single enabled cycle; outside enable it is masked at the port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iter_reg  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      x_out_reg <= '0;
      y_out_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (enable) begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              x_reg    <= xi;
              y_reg    <= yi;
              z_reg    <= zi;
              iter_reg <= '0;
              busy_reg <= 1'b1;
            end
          end
          ROT: begin
            x_reg    <= x_rot;
            y_reg    <= y_rot;
            z_reg    <= z_rot;
            iter_reg <= iter_reg + CW'(1);
          end
          SCALE: begin
            x_reg <= XW'(x_pre >>> SH);
            y_reg <= XW'(y_pre >>> SH);
          end
          OUT: begin
            x_out_reg <= sat(x_reg);
            y_out_reg <= sat(y_reg);
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign x    = x_out_reg;
  assign y    = y_out_reg;
  assign busy = busy_reg;
  assign done = done_reg & enable;

endmodule

// File: tb/tb_pol2rec.sv
// Self-checking bench for pol2rec: directed and random conversions compared
// against a real-valued cos/sin reference, plus latency, stall and abort cases.
module tb_pol2rec;
  import pol2rec_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               start;
  logic [12:0]        mod;
  logic signed [18:0] angle;
  logic signed [13:0] x, y;
  logic               busy, done;

  int checks = 0;
  int errors = 0;

  localparam real PI = 3.14159265358979;

  pol2rec dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .start  (start),
    .mod    (mod),
    .angle  (angle),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input real exp, input real tol);
    logic ok;
    checks++;
    ok = ((($itor(obs) - exp) <= tol) && ((exp - $itor(obs)) <= tol)) ? 1'b1 : 1'b0;
    assert (ok === 1'b1)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0.2f +/- %0.1f", tag, obs, exp, tol);
    end
  endtask

  function automatic real ref_x(input int m, input int a);
    return $itor(m) * $cos($itor(a) / 1024.0 * PI / 180.0);
  endfunction

  function automatic real ref_y(input int m, input int a);
    return $itor(m) * $sin($itor(a) / 1024.0 * PI / 180.0);
  endfunction

  // Launch one conversion and wait (bounded) for done; lat counts edges after start.
  task automatic convert(input int m, input int a, output int lat, output int xo, output int yo);
    @(negedge clock);
    mod   = 13'(m);
    angle = 19'(a);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    xo = int'(x);
    yo = int'(y);
    $display("conv mod=%0d angle=%0d -> x=%0d y=%0d lat=%0d", m, a, xo, yo, lat);
  endtask

  initial begin
    int lat, xo, yo, m, a, ref_xo, ref_yo, ndone, first, stall_done;

    reset  = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    mod    = '0;
    angle  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clock);
    reset = 1'b0;

    // 0 degrees, with latency and single-cycle done
    convert(1000, 0, lat, xo, yo);
    check("lat_0deg", lat, 18);
    check_near("x_0deg", xo, 1000.0, 2.0);
    check_near("y_0deg", yo, 0.0, 2.0);
    @(posedge clock);
    #1;
    check("done_one_cycle", int'(done), 0);
    check("busy_cleared", int'(busy), 0);

    convert(1000, DEG90, lat, xo, yo);
    check_near("x_90deg", xo, 0.0, 2.0);
    check_near("y_90deg", yo, 1000.0, 2.0);

    convert(1000, DEG180, lat, xo, yo);
    check_near("x_180deg", xo, -1000.0, 2.0);
    check_near("y_180deg", yo, 0.0, 2.0);

    convert(4096, -138240, lat, xo, yo);
    check_near("x_m135", xo, -2896.0, 2.0);
    check_near("y_m135", yo, -2896.0, 2.0);

    convert(0, 33333, lat, xo, yo);
    check("x_zero_mod", xo, 0);
    check("y_zero_mod", yo, 0);

    // Full-scale modulus: result must stay inside the symmetric output range
    convert(8191, 0, lat, xo, yo);
    check_near("x_fullscale", xo, 8191.0, 2.0);
    convert(8191, DEG180, lat, xo, yo);
    check_near("x_fullscale_neg", xo, -8191.0, 2.0);
    check("x_fullscale_neg_sat", int'(xo > -8192), 1);

    for (int i = 0; i < 30; i++) begin
      m = int'($urandom_range(4095, 0));
      a = int'($urandom_range(2 * DEG180, 0)) - DEG180;
      convert(m, a, lat, xo, yo);
      check("lat_rand", lat, 18);
      check_near("x_rand", xo, ref_x(m, a), 2.0);
      check_near("y_rand", yo, ref_y(m, a), 2.0);
    end

    // Enable stall: 5 low cycles mid-ROT stretch latency by 5, same result
    convert(3000, 50000, lat, ref_xo, ref_yo);
    @(negedge clock);
    mod   = 13'(3000);
    angle = 19'(50000);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 0;
    stall_done = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      enable = (lat >= 4 && lat < 9) ? 1'b0 : 1'b1;
      if (enable == 1'b0 && done === 1'b1) stall_done++;
      @(posedge clock);
      #1;
      if (enable == 1'b0 && done === 1'b1) stall_done++;
      lat++;
    end
    enable = 1'b1;
    $display("stall conv -> x=%0d y=%0d lat=%0d", int'(x), int'(y), lat);
    check("lat_stall", lat, 23);
    check("x_stall", int'(x), ref_xo);
    check("y_stall", int'(y), ref_yo);
    check("done_masked_stall", stall_done, 0);

    // Second start while busy is ignored
    @(negedge clock);
    mod   = 13'(2000);
    angle = 19'(20000);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    ndone = 0;
    first = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 5) begin
        mod   = 13'(4000);
        angle = -19'sd100000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first = k;
          xo = int'(x);
          yo = int'(y);
        end
      end
    end
    $display("busy-start conv -> x=%0d y=%0d lat=%0d dones=%0d", xo, yo, first, ndone);
    check("dstart_ndone", ndone, 1);
    check("dstart_lat", first, 18);
    check_near("dstart_x", xo, ref_x(2000, 20000), 2.0);
    check_near("dstart_y", yo, ref_y(2000, 20000), 2.0);

    // Asynchronous abort mid-conversion
    @(negedge clock);
    mod   = 13'(3000);
    angle = 19'(10000);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("abort_x", int'(x), 0);
    check("abort_y", int'(y), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) ndone++;
    end
    $display("abort -> dones after release=%0d", ndone);
    check("abort_no_done", ndone, 0);
    convert(1500, -30000, lat, xo, yo);
    check("lat_after_abort", lat, 18);
    check_near("x_after_abort", xo, ref_x(1500, -30000), 2.0);
    check_near("y_after_abort", yo, ref_y(1500, -30000), 2.0);

    // Loop-back of the rectangular point (123, 456) through its polar form
    m = $rtoi($sqrt(123.0 * 123.0 + 456.0 * 456.0) + 0.5);
    a = $rtoi($atan2(456.0, 123.0) * 180.0 / PI * 1024.0 + 0.5);
    convert(m, a, lat, xo, yo);
    check_near("loop_x", xo, 123.0, 3.0);
    check_near("loop_y", yo, 456.0, 3.0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
